cpu_stack_sequencer: RTL and testbench
======================================

Name: cpu_stack_sequencer

Overview:
- Initiator side of the CPU operand-stack Latch/Task interface.
- Accepts one stack-machine opcode per Start request and computes the new top-of-stack value from the stack's current outputs.
- Drives the stack's Address, Input, Task and Latch lines to commit the operation.
- Sits between the CPU instruction decoder and the 8-entry operand stack, and reports Done, Error, Zero and Carry back to the decoder.

Parameters:
- DATA_WIDTH, 8: stack word width. Must match the stack.
- ADDR_WIDTH, 3: stack entry select width (8 entries). Must match the stack.

Ports:
- Clk  input  1  system clock; all state updates on the falling edge, same edge as the stack.
- nReset  input  1  asynchronous active-low reset, shared with the stack.
- Start  input  1  request; sampled only in IDLE.
- Opcode  input  4  operation select; captured with Start.
- Operand  input  DATA_WIDTH  immediate value, or stack index in bits [ADDR_WIDTH-1:0].
- Busy  output  1  high from Start acceptance until Done.
- Done  output  1  one-cycle completion pulse.
- Error  output  1  set for an illegal opcode; cleared on the next accepted Start.
- Zero  output  1  set when the committed top-of-stack value is 0.
- Carry  output  1  ADD carry-out, or SUB borrow; cleared by every other opcode.
- StackAddress  output  ADDR_WIDTH  to stack Address.
- StackInput  output  DATA_WIDTH  to stack Input.
- StackTask  output  2  to stack Task: 00 store s0, 01 push, 10 store s1 then pop, 11 swap s0/sA.
- StackLatch  output  1  to stack Latch; the stack acts on its rising edge.
- StackOut0  input  DATA_WIDTH  from stack s0.
- StackOut1  input  DATA_WIDTH  from stack s1.
- StackOutA  input  DATA_WIDTH  from stack s[Address].

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset mid-operation forces StackLatch low immediately and abandons the operation; no Done pulse.
- States are IDLE, ISSUE, RELEASE.
- IDLE: on a falling edge with Start=1:
  - capture Opcode and Operand;
  - register StackTask, StackAddress and StackInput, computed from StackOut0/1/A as sampled on that edge;
  - set StackLatch=1 and Busy=1; go to ISSUE.
- ISSUE (one cycle): StackLatch=0; the stack commits on this edge; go to RELEASE.
- RELEASE (one cycle): Done=1 for one cycle, Busy=0; update Zero from the committed top-of-stack value; go to IDLE.
- Latency: 3 falling edges from Start sample to Done. Throughput: one operation per 3 cycles.
- Latch guarantees: StackLatch is high for exactly one cycle and low for at least two cycles between pulses, so the stack's edge detector never merges operations.
- Start seen in ISSUE or RELEASE is ignored (not queued). StackAddress, StackInput and StackTask hold their values until the next accepted Start.
- Opcodes (Task, Input, Address; result):
  - 0 PUSH: Task 01, Input = Operand.
  - 1 DUP: Task 01, Input = Out0.
  - 2 OVER: Task 01, Input = Out1.
  - 3 PICK: Task 01, Address = Operand[2:0], Input = OutA.
  - 4 DROP: Task 10, Input = Out1.
  - 5 ADD: Task 10, Input = Out1 + Out0 (mod 2^8); Carry = bit 8 of the 9-bit sum.
  - 6 SUB: Task 10, Input = Out1 - Out0 (mod 2^8); Carry = 1 if Out1 < Out0, unsigned.
  - 7 AND, 8 OR, 9 XOR: Task 10, Input = Out1 op Out0.
  - 10 NOT: Task 00, Input = ~Out0.
  - 11 LOAD: Task 00, Input = Operand.
  - 12 SWAP: Task 11, Address = Operand[2:0]. Operand index 0 is a legal no-op swap.
- Zero is computed from the registered StackInput; for SWAP it is computed from the OutA value sampled at Start.
- Opcodes 13-15 are illegal:
  - no Latch pulse; stack unchanged;
  - same 3-cycle Busy/Done timing;
  - Error=1; Zero and Carry unchanged.
- No overflow or underflow detection: the stack's fixed 8-entry shift semantics apply (push discards s7; pop leaves s7 duplicated in s6 and s7).

Test Plan:
- Reset, then PUSH 0x12, PUSH 0x34, ADD -> Done after 3 cycles each; StackOut0=0x46; Carry=0, Zero=0; exactly one StackLatch pulse per op.
- PUSH 0xF0, PUSH 0x20, ADD -> Out0=0x10, Carry=1. Then PUSH 0x10, SUB -> Out0=0x00, Zero=1, Carry=0.
- PUSH 0x05, PUSH 0x07, SUB -> Out0=0xFE, Carry=1 (borrow). Then NOT -> Out0=0x01, stack depth unchanged.
- Push 0x01..0x08, SWAP with Operand=3 -> Out0=0x05, s3=0x08. PICK 2 -> Out0=0x06, Out1=0x05.
- Opcode 14 -> Busy for 2 cycles, Done pulse, Error=1, StackLatch never high. Next PUSH clears Error.
- Assert Start continuously for 9 cycles with PUSH -> exactly 3 operations accepted; StackLatch low for ≥2 cycles between pulses. Pull nReset low during ISSUE -> StackLatch=0 at once, all outputs 0, no Done.

Source files
------------

// File: rtl/cpu_stack_sequencer.sv
// cpu_stack_sequencer: initiator of the operand-stack Latch/Task handshake, one opcode per Start.
module cpu_stack_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  Clk,
  input  logic                  nReset,
  input  logic                  Start,
  input  logic [3:0]            Opcode,
  input  logic [DATA_WIDTH-1:0] Operand,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic                  Zero,
  output logic                  Carry,
  output logic [ADDR_WIDTH-1:0] StackAddress,
  output logic [DATA_WIDTH-1:0] StackInput,
  output logic [1:0]            StackTask,
  output logic                  StackLatch,
  input  logic [DATA_WIDTH-1:0] StackOut0,
  input  logic [DATA_WIDTH-1:0] StackOut1,
  input  logic [DATA_WIDTH-1:0] StackOutA
);
  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH:0] sum, diff;
  logic [DATA_WIDTH-1:0] nxt_in;
  logic [1:0] nxt_task;
  logic nxt_carry, carry_p, legal, legal_q, sel_a;
  assign legal = Opcode < 4'd13;
  assign sel_a = (Opcode == 4'd3) || (Opcode == 4'd12);
  // PICK/SWAP steer the address ahead of the sampling edge so StackOutA shows the target entry
  assign StackAddress = (state == IDLE && Start && sel_a) ? Operand[ADDR_WIDTH-1:0] : addr_q;
  always_comb begin
    sum = {1'b0, StackOut1} + {1'b0, StackOut0};
    diff = {1'b0, StackOut1} - {1'b0, StackOut0};
    nxt_task = 2'b10;
    nxt_in = StackOut1;
    nxt_carry = 1'b0;
    case (Opcode)
      4'd0: begin nxt_task = 2'b01; nxt_in = Operand; end
      4'd1: begin nxt_task = 2'b01; nxt_in = StackOut0; end
      4'd2: nxt_task = 2'b01;
      4'd3: begin nxt_task = 2'b01; nxt_in = StackOutA; end
      4'd5: begin nxt_in = sum[DATA_WIDTH-1:0]; nxt_carry = sum[DATA_WIDTH]; end
      4'd6: begin nxt_in = diff[DATA_WIDTH-1:0]; nxt_carry = diff[DATA_WIDTH]; end
      4'd7: nxt_in = StackOut1 & StackOut0;
      4'd8: nxt_in = StackOut1 | StackOut0;
      4'd9: nxt_in = StackOut1 ^ StackOut0;
      4'd10: begin nxt_task = 2'b00; nxt_in = ~StackOut0; end
      4'd11: begin nxt_task = 2'b00; nxt_in = Operand; end
      4'd12: begin nxt_task = 2'b11; nxt_in = StackOutA; end
      default: ;
    endcase
  end
  always_ff @(negedge Clk or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
      Busy <= 1'b0;
      Done <= 1'b0;
      Error <= 1'b0;
      Zero <= 1'b0;
      Carry <= 1'b0;
      addr_q <= '0;
      StackInput <= '0;
      StackTask <= 2'b00;
      StackLatch <= 1'b0;
      carry_p <= 1'b0;
      legal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            Busy <= 1'b1;
            Error <= !legal;
            legal_q <= legal;
            StackLatch <= legal;
            carry_p <= nxt_carry;
            if (legal) begin
              StackTask <= nxt_task;
              StackInput <= nxt_in;
            end
            if (sel_a) addr_q <= Operand[ADDR_WIDTH-1:0];
            state <= ISSUE;
          end
        end
        ISSUE: begin
          StackLatch <= 1'b0;
          state <= RELEASE;
        end
        RELEASE: begin
          Done <= 1'b1;
          Busy <= 1'b0;
          if (legal_q) begin
            Zero <= StackInput == '0;
            Carry <= carry_p;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_stack_sequencer.sv
// tb_cpu_stack_sequencer: drives the sequencer against an 8-entry stack and checks it with an abstract stack model.
module tb_cpu_stack_sequencer;
  logic Clk = 1'b0, nReset = 1'b0, Start = 1'b0;
  logic [3:0] Opcode = 4'd0;
  logic [7:0] Operand = 8'd0;
  logic Busy, Done, Error, Zero, Carry, StackLatch;
  logic [2:0] StackAddress;
  logic [7:0] StackInput, StackOut0, StackOut1, StackOutA;
  logic [1:0] StackTask;
  int total = 0, passed = 0, failed = 0;
  int pulses = 0, hi_run = 0, lo_run = 0, min_gap = 99, max_hi = 0;
  logic seen = 1'b0;
  logic [7:0] s [8];
  logic lp;
  logic [7:0] r [8];
  logic ez = 1'b0, ec = 1'b0, ee = 1'b0;

  always #5 Clk = ~Clk;

  cpu_stack_sequencer dut (
    .Clk(Clk), .nReset(nReset), .Start(Start), .Opcode(Opcode), .Operand(Operand),
    .Busy(Busy), .Done(Done), .Error(Error), .Zero(Zero), .Carry(Carry),
    .StackAddress(StackAddress), .StackInput(StackInput), .StackTask(StackTask),
    .StackLatch(StackLatch), .StackOut0(StackOut0), .StackOut1(StackOut1), .StackOutA(StackOutA)
  );

  // operand stack: acts on the Latch rising edge seen at a falling clock edge
  assign StackOut0 = s[0];
  assign StackOut1 = s[1];
  assign StackOutA = s[StackAddress];
  always @(negedge Clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < 8; i++) s[i] <= 8'd0;
      lp <= 1'b0;
    end else begin
      lp <= StackLatch;
      if (StackLatch && !lp) begin
        case (StackTask)
          2'b00: s[0] <= StackInput;
          2'b01: begin for (int i = 7; i > 0; i--) s[i] <= s[i-1]; s[0] <= StackInput; end
          2'b10: begin for (int i = 1; i < 7; i++) s[i] <= s[i+1]; s[0] <= StackInput; end
          default: begin s[0] <= s[StackAddress]; s[StackAddress] <= s[0]; end
        endcase
      end
    end
  end

  always @(posedge Clk) begin
    #2;
    if (StackLatch) begin
      if (hi_run == 0) pulses++;
      if (seen && lo_run < min_gap) min_gap = lo_run;
      hi_run++;
      if (hi_run > max_hi) max_hi = hi_run;
      lo_run = 0;
      seen = 1'b1;
    end else begin
      hi_run = 0;
      lo_run++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_push(input logic [7:0] v);
    for (int i = 7; i > 0; i--) r[i] = r[i-1];
    r[0] = v;
  endfunction

  function automatic void ref_pop(input logic [7:0] v);
    for (int i = 1; i < 7; i++) r[i] = r[i+1];
    r[0] = v;
  endfunction

  function automatic void ref_op(input logic [3:0] op, input logic [7:0] opr);
    int a, b, t;
    logic [2:0] k;
    logic [7:0] tmp;
    a = int'(r[0]);
    b = int'(r[1]);
    k = opr[2:0];
    if (op > 4'd12) begin
      ee = 1'b1;
      return;
    end
    ee = 1'b0;
    ec = 1'b0;
    case (op)
      4'd0: ref_push(opr);
      4'd1: ref_push(r[0]);
      4'd2: ref_push(r[1]);
      4'd3: ref_push(r[k]);
      4'd4: ref_pop(r[1]);
      4'd5: begin t = b + a; ref_pop(8'(t % 256)); ec = t > 255; end
      4'd6: begin t = b - a; ref_pop(8'((t + 256) % 256)); ec = b < a; end
      4'd7: ref_pop(r[1] & r[0]);
      4'd8: ref_pop(r[1] | r[0]);
      4'd9: ref_pop(r[1] ^ r[0]);
      4'd10: r[0] = ~r[0];
      4'd11: r[0] = opr;
      default: begin tmp = r[0]; r[0] = r[k]; r[k] = tmp; end
    endcase
    ez = r[0] == 8'd0;
  endfunction

  function automatic void ref_reset();
    for (int i = 0; i < 8; i++) r[i] = 8'd0;
    ez = 1'b0;
    ec = 1'b0;
    ee = 1'b0;
  endfunction

  task automatic check_stack();
    for (int i = 0; i < 8; i++) chk($sformatf("s%0d", i), 32'(s[i]), 32'(r[i]));
  endtask

  task automatic do_op(input logic [3:0] op, input logic [7:0] opr);
    int n, p0;
    @(posedge Clk);
    Start = 1'b1; Opcode = op; Operand = opr; p0 = pulses;
    @(posedge Clk);
    Start = 1'b0;
    chk("busy_set", 32'(Busy), 32'd1);
    chk("done_early", 32'(Done), 32'd0);
    n = 1;
    while (!Done && n < 8) begin
      @(posedge Clk);
      n++;
    end
    ref_op(op, opr);
    chk($sformatf("latency op%0d", op), 32'(n), 32'd3);
    chk("busy_clr", 32'(Busy), 32'd0);
    chk($sformatf("error op%0d", op), 32'(Error), 32'(ee));
    chk($sformatf("zero op%0d", op), 32'(Zero), 32'(ez));
    chk($sformatf("carry op%0d", op), 32'(Carry), 32'(ec));
    chk($sformatf("pulses op%0d", op), 32'(pulses - p0), 32'(op < 4'd13));
    check_stack();
    @(posedge Clk);
    chk("done_pulse", 32'(Done), 32'd0);
  endtask

  initial begin
    int d, p0;
    ref_reset();
    repeat (3) @(posedge Clk);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_outs", 32'({Done, Error, Zero, Carry, StackLatch, StackTask, StackInput, StackAddress}), 32'd0);
    nReset = 1'b1;
    do_op(4'd0, 8'h12); do_op(4'd0, 8'h34); do_op(4'd5, 8'h00);
    chk("plan_add", 32'(StackOut0), 32'h46);
    do_op(4'd0, 8'hF0); do_op(4'd0, 8'h20); do_op(4'd5, 8'h00);
    chk("plan_add_wrap", 32'(StackOut0), 32'h10);
    chk("plan_add_carry", 32'(Carry), 32'd1);
    do_op(4'd0, 8'h10); do_op(4'd6, 8'h00);
    chk("plan_sub_zero", 32'({StackOut0, Zero, Carry}), 32'({8'h00, 1'b1, 1'b0}));
    do_op(4'd0, 8'h05); do_op(4'd0, 8'h07); do_op(4'd6, 8'h00);
    chk("plan_borrow", 32'({StackOut0, Carry}), 32'({8'hFE, 1'b1}));
    do_op(4'd10, 8'h00);
    chk("plan_not", 32'(StackOut0), 32'h01);
    for (int i = 1; i <= 8; i++) do_op(4'd0, 8'(i));
    do_op(4'd12, 8'h03);
    chk("plan_swap", 32'({s[0], s[3]}), 32'h0508);
    do_op(4'd3, 8'h02);
    chk("plan_pick", 32'({StackOut0, StackOut1}), 32'h0605);
    do_op(4'd12, 8'h00);
    do_op(4'd14, 8'hAA);
    chk("plan_illegal", 32'(Error), 32'd1);
    do_op(4'd0, 8'h99);
    chk("plan_err_clear", 32'(Error), 32'd0);
    // Start held high for nine edges: only every third edge can accept
    p0 = pulses; d = 0;
    @(posedge Clk);
    Start = 1'b1; Opcode = 4'd0; Operand = 8'h5A;
    repeat (9) begin
      @(negedge Clk);
      @(posedge Clk);
      if (Done) d++;
    end
    Start = 1'b0;
    repeat (3) ref_op(4'd0, 8'h5A);
    chk("cont_done", 32'(d), 32'd3);
    chk("cont_pulses", 32'(pulses - p0), 32'd3);
    chk("latch_gap", 32'(min_gap >= 2), 32'd1);
    chk("latch_width", 32'(max_hi), 32'd1);
    check_stack();
    repeat (2) @(posedge Clk);
    Start = 1'b1; Opcode = 4'd0; Operand = 8'h77;
    @(negedge Clk);
    @(posedge Clk);
    Start = 1'b0;
    chk("issue_latch", 32'(StackLatch), 32'd1);
    nReset = 1'b0;
    #1;
    chk("rst_mid_latch", 32'(StackLatch), 32'd0);
    chk("rst_mid_outs", 32'({Busy, Done, Error, Zero, Carry, StackTask, StackInput, StackAddress}), 32'd0);
    d = 0;
    repeat (4) begin
      @(posedge Clk);
      if (Done) d++;
    end
    chk("rst_no_done", 32'(d), 32'd0);
    nReset = 1'b1;
    ref_reset();
    check_stack();
    for (int i = 0; i < 40; i++) do_op(4'($urandom_range(15)), 8'($urandom));
    chk("latch_gap_final", 32'(min_gap >= 2), 32'd1);
    chk("latch_width_final", 32'(max_hi), 32'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
